// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed, checksummed image into instruction memory
// and holds the core in reset until a load completes cleanly.
module instr_mem_loader #(
    parameter int ADR_W    = 20,
    parameter int BASE_ADR = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    output logic             o_wr_en,
    output logic [ADR_W-1:0] o_wr_adr,
    output logic [7:0]       o_wr_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_cpu_rst
);

    // Wide enough that BASE_ADR + 4*N can never wrap for any 32-bit N.
    localparam int CW = ADR_W + 36;
    localparam logic [CW-1:0]    LIMIT  = CW'(1) << ADR_W;
    localparam logic [CW-1:0]    BASE_W = CW'(BASE_ADR);
    localparam logic [ADR_W-1:0] BASE_A = ADR_W'(BASE_ADR);

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, CHK, DONE, ERR
    } state_t;

    state_t           state;
    logic [ADR_W-1:0] cnt;
    logic [ADR_W-1:0] last;
    logic [23:0]      sh;
    logic [31:0]      csum;
    logic [31:0]      word;
    logic [CW-1:0]    need;
    logic             take;
    logic             last_b;

    assign take   = i_byte_valid & o_byte_ready;
    assign word   = {i_byte, sh};
    assign need   = BASE_W + CW'({word, 2'b00});
    assign last_b = (cnt[1:0] == 2'd3);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            last         <= '0;
            sh           <= '0;
            csum         <= '0;
            o_byte_ready <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_adr     <= '0;
            o_wr_data    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_cpu_rst    <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (i_start) begin
                        state        <= HDR;
                        cnt          <= '0;
                        sh           <= '0;
                        csum         <= '0;
                        o_byte_ready <= 1'b1;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_err        <= 1'b0;
                        o_cpu_rst    <= 1'b0;
                    end
                end
                HDR: begin
                    if (take) begin
                        sh  <= word[31:8];
                        cnt <= cnt + 1'b1;
                        if (last_b) begin
                            cnt  <= '0;
                            last <= ADR_W'({word - 32'd1, 2'b11});
                            if (need > LIMIT) begin
                                state        <= ERR;
                                o_err        <= 1'b1;
                                o_byte_ready <= 1'b0;
                                o_busy       <= 1'b0;
                            end else if (word == 32'd0) begin
                                state <= CHK;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        sh        <= word[31:8];
                        cnt       <= cnt + 1'b1;
                        o_wr_en   <= 1'b1;
                        o_wr_adr  <= BASE_A + cnt;
                        o_wr_data <= i_byte;
                        if (last_b)
                            csum <= csum ^ word;
                        if (cnt == last) begin
                            cnt   <= '0;
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (take) begin
                        sh  <= word[31:8];
                        cnt <= cnt + 1'b1;
                        if (last_b) begin
                            cnt          <= '0;
                            o_byte_ready <= 1'b0;
                            o_busy       <= 1'b0;
                            if (word == csum) begin
                                state     <= DONE;
                                o_done    <= 1'b1;
                                o_cpu_rst <= 1'b1;
                            end else begin
                                state <= ERR;
                                o_err <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench: default-sized loader plus a tiny 16-byte instance
// at base 8 for the size-limit cases.
module tb_instr_mem_loader;

    logic        clk = 0;
    logic        rst = 0;
    logic        start0 = 0;
    logic        start1 = 0;
    logic [7:0]  b = 0;
    logic        bv = 0;
    logic        sel = 0;

    logic        rdy0, we0, busy0, done0, err0, crst0;
    logic [19:0] adr0;
    logic [7:0]  dat0;
    logic        rdy1, we1, busy1, done1, err1, crst1;
    logic [3:0]  adr1;
    logic [7:0]  dat1;
    logic        rdy;

    int total = 0;
    int bad = 0;

    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    logic [31:0] ew[2];

    instr_mem_loader u0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0),
        .i_byte(b), .i_byte_valid(bv), .o_byte_ready(rdy0),
        .o_wr_en(we0), .o_wr_adr(adr0), .o_wr_data(dat0),
        .o_busy(busy0), .o_done(done0), .o_err(err0),
        .o_cpu_rst(crst0)
    );

    instr_mem_loader #(.ADR_W(4), .BASE_ADR(8)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1),
        .i_byte(b), .i_byte_valid(bv), .o_byte_ready(rdy1),
        .o_wr_en(we1), .o_wr_adr(adr1), .o_wr_data(dat1),
        .o_busy(busy1), .o_done(done1), .o_err(err1),
        .o_cpu_rst(crst1)
    );

    always #5 clk = ~clk;

    assign rdy = sel ? rdy1 : rdy0;

    always @(negedge clk) begin
        if (!sel && we0) begin
            wa.push_back(32'(adr0));
            wd.push_back(dat0);
        end
        if (sel && we1) begin
            wa.push_back(32'(adr1));
            wd.push_back(dat1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        if (sel) start1 = 1; else start0 = 1;
        tick(1);
        start0 = 0;
        start1 = 0;
    endtask

    task automatic send(input logic [7:0] v, input int gap);
        bit ok = 0;
        repeat (gap) begin
            bv = 0;
            tick(1);
        end
        b  = v;
        bv = 1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (rdy) begin
                tick(1);
                ok = 1;
            end
        end
        bv = 0;
        if (!ok) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send4(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++)
            send(w[8*i +: 8], gap);
    endtask

    task automatic check_log(input string tag, input int nb,
                             input int base);
        logic [31:0] w;
        chk({tag, "_count"}, 32'(wa.size()), 32'(nb));
        for (int i = 0; i < nb && i < wa.size(); i++) begin
            w = ew[i / 4] >> (8 * (i % 4));
            chk({tag, "_adr"}, wa[i], 32'(base + i));
            chk({tag, "_dat"}, 32'(wd[i]), 32'(w[7:0]));
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        #2;
        chk("rst_ready", 32'(rdy0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_cpu", 32'(crst0), 0);
        chk("rst_wr_en", 32'(we0), 0);
        tick(1);
        rst = 1;
        tick(3);
        chk("idle_busy", 32'(busy0), 0);
        chk("idle_ready", 32'(rdy0), 0);

        // N=1 single word
        clear_log();
        ew[0] = 32'h0000_0013;
        pulse_start();
        chk("hdr_busy", 32'(busy0), 1);
        chk("hdr_cpu", 32'(crst0), 0);
        send4(32'd1, 0);
        send4(32'h0000_0013, 0);
        send4(32'h0000_0013, 0);
        chk("n1_done", 32'(done0), 1);
        chk("n1_cpu", 32'(crst0), 1);
        chk("n1_err", 32'(err0), 0);
        chk("n1_busy", 32'(busy0), 0);
        tick(2);
        check_log("n1", 4, 0);

        // N=2 with valid toggling and a long stall mid-payload
        clear_log();
        ew[0] = 32'h0050_0093;
        ew[1] = 32'h00A0_0113;
        pulse_start();
        chk("n2_cpu_low", 32'(crst0), 0);
        chk("n2_done_clr", 32'(done0), 0);
        send4(32'd2, 1);
        send(8'h93, 1);
        send(8'h00, 1);
        send(8'h50, 1);
        tick(20);
        chk("stall_busy", 32'(busy0), 1);
        chk("stall_ready", 32'(rdy0), 1);
        chk("stall_writes", 32'(wa.size()), 3);
        send(8'h00, 1);
        send4(32'h00A0_0113, 1);
        send4(32'h00F0_0180, 1);
        chk("n2_done", 32'(done0), 1);
        tick(2);
        check_log("n2", 8, 0);

        // N=0 good and bad checksum
        clear_log();
        pulse_start();
        send4(32'd0, 0);
        send4(32'd0, 0);
        chk("n0_done", 32'(done0), 1);
        tick(2);
        chk("n0_writes", 32'(wa.size()), 0);
        pulse_start();
        send4(32'd0, 0);
        send4(32'd1, 0);
        chk("n0bad_err", 32'(err0), 1);
        chk("n0bad_done", 32'(done0), 0);
        chk("n0bad_cpu", 32'(crst0), 0);
        tick(3);
        chk("err_ignores", 32'(rdy0), 0);

        // Small instance: ADR_W=4, BASE_ADR=8
        sel = 1;
        clear_log();
        pulse_start();
        send4(32'd3, 0);
        chk("ovf_err", 32'(err1), 1);
        chk("ovf_busy", 32'(busy1), 0);
        tick(2);
        chk("ovf_writes", 32'(wa.size()), 0);
        ew[0] = 32'h0403_0201;
        ew[1] = 32'h0807_0605;
        pulse_start();
        chk("fit_err_clr", 32'(err1), 0);
        send4(32'd2, 0);
        chk("fit_busy", 32'(busy1), 1);
        send4(ew[0], 0);
        send4(ew[1], 0);
        chk("fit_in_chk", 32'(busy1), 1);
        send4(32'h0C04_0404, 0);
        chk("fit_done", 32'(done1), 1);
        tick(2);
        check_log("fit", 8, 8);
        sel = 0;

        // Reset pulse mid-payload, then a clean reload
        clear_log();
        ew[0] = 32'h0050_0093;
        ew[1] = 32'h00A0_0113;
        pulse_start();
        send4(32'd2, 0);
        send4(ew[0], 0);
        send(8'h13, 0);
        @(negedge clk);
        #1;
        rst = 0;
        #1;
        chk("mid_ready", 32'(rdy0), 0);
        chk("mid_wr_en", 32'(we0), 0);
        chk("mid_adr", 32'(adr0), 0);
        chk("mid_dat", 32'(dat0), 0);
        chk("mid_busy", 32'(busy0), 0);
        chk("mid_done", 32'(done0), 0);
        chk("mid_err", 32'(err0), 0);
        chk("mid_cpu", 32'(crst0), 0);
        tick(2);
        rst = 1;
        tick(5);
        chk("mid_writes", 32'(wa.size()), 5);
        chk("mid_idle", 32'(busy0), 0);
        clear_log();
        pulse_start();
        send4(32'd2, 0);
        send4(ew[0], 0);
        send4(ew[1], 0);
        send4(32'h00F0_0180, 0);
        chk("reload_done", 32'(done0), 1);
        tick(2);
        check_log("reload", 8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
